mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: MAX_WAIT, default 15, maximum BUSY cycles without mem_ack_i before the access is aborted (legal 1..255).
REQ-002 clk_i  in  1  single clock; all state updates on posedge clk_i.
REQ-003 rst_i  in  1  reset; synchronous and active-low, sampled on posedge clk_i.
REQ-004 MemRd_i, MemWr_i, MemtoReg_i, RegWrite_i  in  1 each  control bits from the EX/MEM register.
REQ-005 ALUResult_i  in  32  memory address, or result for non-memory ops; MemData_i  in  32  store data; WriteReg_i  in  5  destination register.
REQ-006 mem_req_o  out  1  data-memory request; mem_we_o  out  1  1=write; mem_addr_o, mem_wdata_o  out  32  latched address and store data.
REQ-007 mem_ack_i  in  1  memory completion; mem_rdata_i  in  32  load data, valid when mem_ack_i=1.
REQ-008 stall_o  out  1  combinational freeze request to all upstream pipeline registers.
REQ-009 MemtoReg_o, RegWrite_o  out  1; ReadData_o, ALUResult_o  out  32; WriteReg_o  out  5  registered MEM/WB outputs.
REQ-010 err_o  out  1  sticky fault flag; err_addr_o  out  32  address of the first fault.

Function
REQ-011 Memory op = MemRd_i|MemWr_i; aligned = ALUResult_i[1:0]==2'b00; mem_we_o = 1 when MemWr_i=1 (write wins when both bits are 1).
REQ-012 FSM states: IDLE, BUSY; reset state is IDLE.
REQ-013 IDLE, no memory op: MEM/WB loads inputs directly (ReadData_o=0); stall_o=0; 1-cycle latency.
REQ-014 IDLE, aligned memory op: stall_o=1 in the same cycle; next edge -> BUSY, mem_req_o=1, with mem_addr_o, mem_wdata_o, mem_we_o, control bits and WriteReg latched; MEM/WB loads a bubble.
REQ-015 IDLE, misaligned memory op: no request, stall_o=0, MEM/WB loads a bubble; err_o set and err_addr_o=ALUResult_i only if err_o was 0.
REQ-016 Bubble = RegWrite_o=0, MemtoReg_o=0; data outputs hold their previous values.
REQ-017 BUSY: mem_req_o and all latched mem_* outputs held stable until completion or abort; inputs ignored.
REQ-018 BUSY, mem_ack_i=0: stall_o=1, wait counter increments, MEM/WB loads a bubble.
REQ-019 BUSY, mem_ack_i=1: stall_o=0 in that cycle; at the edge MEM/WB loads the latched control bits, WriteReg and address (ALUResult_o), with ReadData_o=mem_rdata_i for reads and 0 for writes; mem_req_o->0; counter->0; state->IDLE.
REQ-020 Minimum latency of a memory op is 2 cycles: op presented in cycle N, ack accepted in N+1, WB outputs valid after the N+1 edge.
REQ-021 Timeout: BUSY, mem_ack_i=0, counter==MAX_WAIT-1: stall_o=0; at the edge abort (mem_req_o->0, bubble, state->IDLE, counter->0); err_o set with the latched address if err_o was 0.
REQ-022 mem_ack_i in IDLE is ignored.
REQ-023 An ack arriving in the same cycle the timeout would fire completes the access normally; ack wins.
REQ-024 The wait counter is 8 bits and never wraps.

Reset
REQ-025 rst_i=0 at an edge: state IDLE; counter 0; mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o 0; all MEM/WB outputs 0; err_o 0; err_addr_o 0.
REQ-026 Reset while BUSY drops mem_req_o at that edge, and any later ack is ignored.
REQ-027 stall_o=0 while rst_i=0.

Verification
REQ-028 ALU op: RegWrite_i=1, ALUResult_i=0x1234, WriteReg_i=5, no memory op -> next edge RegWrite_o=1, ALUResult_o=0x1234, WriteReg_o=5, stall_o stays 0.
REQ-029 Load from 0x40, ack in the first BUSY cycle with rdata 0xDEADBEEF -> stall_o high for exactly 1 cycle, then MemtoReg_o=1, ReadData_o=0xDEADBEEF, WriteReg_o correct.
REQ-030 Store to 0x80, data 0x55, ack after 3 wait cycles -> mem_we_o=1, addr and data stable throughout, stall_o high for 4 cycles, RegWrite_o=0 every cycle.
REQ-031 Load from 0x42 (misaligned) -> no mem_req_o, err_o=1, err_addr_o=0x42, RegWrite_o=0; a later fault at 0x81 leaves err_addr_o=0x42.
REQ-032 MAX_WAIT=4, no ack -> mem_req_o high for 4 cycles then 0, err_o=1, state IDLE, next ALU op passes normally.
REQ-033 rst_i=0 during the second BUSY cycle -> next edge all outputs 0; an ack one cycle later produces no register write.

Source files
------------

// File: rtl/mem_stage.sv
// MEM pipeline stage: drives a request/ack data-memory port and stalls upstream
// while an access is outstanding. An outstanding access is aborted after MAX_WAIT
// un-acked cycles. A sticky error flag captures the first misaligned or timed-out address.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRd_i,
    input  logic        MemWr_i,
    input  logic        MemtoReg_i,
    input  logic        RegWrite_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] MemData_i,
    input  logic [4:0]  WriteReg_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        MemtoReg_o,
    output logic        RegWrite_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] ALUResult_o,
    output logic [4:0]  WriteReg_o,
    output logic        err_o,
    output logic [31:0] err_addr_o
);

    typedef enum logic [0:0] {StIdle, StBusy} state_t;

    localparam logic [7:0] LastWait = 8'(MAX_WAIT - 1);

    state_t      stateQ, stateD;
    logic [7:0]  waitCntQ, waitCntD;
    logic        memReqQ, memReqD;
    logic        memWeQ, memWeD;
    logic [31:0] memAddrQ, memAddrD;
    logic [31:0] memWdataQ, memWdataD;
    // Control bits of the outstanding access, replayed into MEM/WB on completion
    logic        latMemtoRegQ, latMemtoRegD;
    logic        latRegWriteQ, latRegWriteD;
    logic [4:0]  latWriteRegQ, latWriteRegD;
    // MEM/WB register
    logic        memtoRegQ, memtoRegD;
    logic        regWriteQ, regWriteD;
    logic [31:0] readDataQ, readDataD;
    logic [31:0] aluResultQ, aluResultD;
    logic [4:0]  writeRegQ, writeRegD;
    logic        errQ, errD;
    logic [31:0] errAddrQ, errAddrD;
    logic        stall;
    logic        memOp;
    logic        aligned;

    assign memOp   = MemRd_i | MemWr_i;
    assign aligned = (ALUResult_i[1:0] == 2'b00);

    // Next-state, MEM/WB load selection and stall request
    always_comb begin
        stateD       = stateQ;
        waitCntD     = waitCntQ;
        memReqD      = memReqQ;
        memWeD       = memWeQ;
        memAddrD     = memAddrQ;
        memWdataD    = memWdataQ;
        latMemtoRegD = latMemtoRegQ;
        latRegWriteD = latRegWriteQ;
        latWriteRegD = latWriteRegQ;
        memtoRegD    = memtoRegQ;
        regWriteD    = regWriteQ;
        readDataD    = readDataQ;
        aluResultD   = aluResultQ;
        writeRegD    = writeRegQ;
        errD         = errQ;
        errAddrD     = errAddrQ;
        stall        = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (memOp) begin
                    // Bubble: control cleared, data outputs hold
                    memtoRegD = 1'b0;
                    regWriteD = 1'b0;
                    if (aligned) begin
                        stall        = 1'b1;
                        stateD       = StBusy;
                        waitCntD     = 8'd0;
                        memReqD      = 1'b1;
                        memWeD       = MemWr_i;
                        memAddrD     = ALUResult_i;
                        memWdataD    = MemData_i;
                        latMemtoRegD = MemtoReg_i;
                        latRegWriteD = RegWrite_i;
                        latWriteRegD = WriteReg_i;
                    end else if (!errQ) begin
                        errD     = 1'b1;
                        errAddrD = ALUResult_i;
                    end
                end else begin
                    memtoRegD  = MemtoReg_i;
                    regWriteD  = RegWrite_i;
                    readDataD  = 32'd0;
                    aluResultD = ALUResult_i;
                    writeRegD  = WriteReg_i;
                end
            end
            StBusy: begin
                memtoRegD = 1'b0;
                regWriteD = 1'b0;
                // Ack is checked first so it beats a timeout in the same cycle
                if (mem_ack_i) begin
                    memtoRegD  = latMemtoRegQ;
                    regWriteD  = latRegWriteQ;
                    writeRegD  = latWriteRegQ;
                    aluResultD = memAddrQ;
                    readDataD  = memWeQ ? 32'd0 : mem_rdata_i;
                    memReqD    = 1'b0;
                    waitCntD   = 8'd0;
                    stateD     = StIdle;
                end else if (waitCntQ == LastWait) begin
                    memReqD  = 1'b0;
                    waitCntD = 8'd0;
                    stateD   = StIdle;
                    if (!errQ) begin
                        errD     = 1'b1;
                        errAddrD = memAddrQ;
                    end
                end else begin
                    stall = 1'b1;
                    if (waitCntQ != 8'hFF) waitCntD = waitCntQ + 8'd1;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    // All state updates; reset is synchronous and active-low
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stateQ       <= StIdle;
            waitCntQ     <= 8'd0;
            memReqQ      <= 1'b0;
            memWeQ       <= 1'b0;
            memAddrQ     <= 32'd0;
            memWdataQ    <= 32'd0;
            latMemtoRegQ <= 1'b0;
            latRegWriteQ <= 1'b0;
            latWriteRegQ <= 5'd0;
            memtoRegQ    <= 1'b0;
            regWriteQ    <= 1'b0;
            readDataQ    <= 32'd0;
            aluResultQ   <= 32'd0;
            writeRegQ    <= 5'd0;
            errQ         <= 1'b0;
            errAddrQ     <= 32'd0;
        end else begin
            stateQ       <= stateD;
            waitCntQ     <= waitCntD;
            memReqQ      <= memReqD;
            memWeQ       <= memWeD;
            memAddrQ     <= memAddrD;
            memWdataQ    <= memWdataD;
            latMemtoRegQ <= latMemtoRegD;
            latRegWriteQ <= latRegWriteD;
            latWriteRegQ <= latWriteRegD;
            memtoRegQ    <= memtoRegD;
            regWriteQ    <= regWriteD;
            readDataQ    <= readDataD;
            aluResultQ   <= aluResultD;
            writeRegQ    <= writeRegD;
            errQ         <= errD;
            errAddrQ     <= errAddrD;
        end
    end

    // Stall is suppressed while reset is asserted
    assign stall_o     = rst_i & stall;
    assign mem_req_o   = memReqQ;
    assign mem_we_o    = memWeQ;
    assign mem_addr_o  = memAddrQ;
    assign mem_wdata_o = memWdataQ;
    assign MemtoReg_o  = memtoRegQ;
    assign RegWrite_o  = regWriteQ;
    assign ReadData_o  = readDataQ;
    assign ALUResult_o = aluResultQ;
    assign WriteReg_o  = writeRegQ;
    assign err_o       = errQ;
    assign err_addr_o  = errAddrQ;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with MAX_WAIT=4; inputs change and outputs are sampled on negedge.
module tb_mem_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRd_i, MemWr_i, MemtoReg_i, RegWrite_i;
    logic [31:0] ALUResult_i, MemData_i;
    logic [4:0]  WriteReg_i;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        MemtoReg_o, RegWrite_o;
    logic [31:0] ReadData_o, ALUResult_o;
    logic [4:0]  WriteReg_o;
    logic        err_o;
    logic [31:0] err_addr_o;

    int nTests = 0;
    int nFail  = 0;

    mem_stage #(.MAX_WAIT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .MemRd_i(MemRd_i), .MemWr_i(MemWr_i), .MemtoReg_i(MemtoReg_i), .RegWrite_i(RegWrite_i),
        .ALUResult_i(ALUResult_i), .MemData_i(MemData_i), .WriteReg_i(WriteReg_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o),
        .ReadData_o(ReadData_o), .ALUResult_o(ALUResult_o), .WriteReg_o(WriteReg_o),
        .err_o(err_o), .err_addr_o(err_addr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle_inputs();
        MemRd_i = 0; MemWr_i = 0; MemtoReg_i = 0; RegWrite_i = 0;
        ALUResult_i = 0; MemData_i = 0; WriteReg_i = 0;
        mem_ack_i = 0; mem_rdata_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 0;
        @(negedge clk_i);
        MemRd_i = 1; ALUResult_i = 32'h40;
        #1;
        nTests++;
        if (stall_o !== 1'b0) begin
            nFail++; $display("FAIL reset_stall: got %b want 0", stall_o);
        end
        @(negedge clk_i);
        nTests++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, MemtoReg_o, RegWrite_o, ReadData_o,
             ALUResult_o, WriteReg_o, err_o, err_addr_o} !== '0) begin
            nFail++; $display("FAIL reset_outputs: req=%b addr=%h rw=%b err=%b", mem_req_o,
                              mem_addr_o, RegWrite_o, err_o);
        end
        idle_inputs();
        rst_i = 1;
    endtask

    task automatic test_alu();
        @(negedge clk_i);
        RegWrite_i = 1; ALUResult_i = 32'h1234; WriteReg_i = 5;
        #1;
        nTests++;
        if (stall_o !== 1'b0) begin
            nFail++; $display("FAIL alu_stall: got %b want 0", stall_o);
        end
        @(negedge clk_i);
        nTests++;
        if (RegWrite_o !== 1'b1 || ALUResult_o !== 32'h1234 || WriteReg_o !== 5'd5 ||
            MemtoReg_o !== 1'b0 || ReadData_o !== 32'd0) begin
            nFail++; $display("FAIL alu_wb: rw=%b alu=%h wr=%0d m2r=%b rd=%h want 1 1234 5 0 0",
                              RegWrite_o, ALUResult_o, WriteReg_o, MemtoReg_o, ReadData_o);
        end
    endtask

    task automatic test_load();
        int stalls = 0;
        @(negedge clk_i);
        MemRd_i = 1; MemtoReg_i = 1; RegWrite_i = 1; ALUResult_i = 32'h40; WriteReg_i = 7;
        #1;
        if (stall_o) stalls++;
        @(negedge clk_i);
        nTests++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h40) begin
            nFail++; $display("FAIL load_req: req=%b we=%b addr=%h want 1 0 40",
                              mem_req_o, mem_we_o, mem_addr_o);
        end
        nTests++;
        if (RegWrite_o !== 1'b0 || MemtoReg_o !== 1'b0 || ALUResult_o !== 32'h1234 ||
            WriteReg_o !== 5'd5) begin
            nFail++; $display("FAIL load_bubble: rw=%b m2r=%b alu=%h wr=%0d want 0 0 1234 5",
                              RegWrite_o, MemtoReg_o, ALUResult_o, WriteReg_o);
        end
        idle_inputs();
        mem_ack_i = 1; mem_rdata_i = 32'hDEADBEEF;
        #1;
        if (stall_o) stalls++;
        @(negedge clk_i);
        mem_ack_i = 0; mem_rdata_i = 0;
        #1;
        if (stall_o) stalls++;
        nTests++;
        if (MemtoReg_o !== 1'b1 || RegWrite_o !== 1'b1 || ReadData_o !== 32'hDEADBEEF ||
            WriteReg_o !== 5'd7 || ALUResult_o !== 32'h40 || mem_req_o !== 1'b0) begin
            nFail++; $display("FAIL load_wb: m2r=%b rw=%b rd=%h wr=%0d alu=%h req=%b",
                              MemtoReg_o, RegWrite_o, ReadData_o, WriteReg_o, ALUResult_o,
                              mem_req_o);
        end
        nTests++;
        if (stalls != 1) begin
            nFail++; $display("FAIL load_stall_cycles: got %0d want 1", stalls);
        end
    endtask

    task automatic test_store();
        int stalls = 0;
        int bad = 0;
        @(negedge clk_i);
        MemWr_i = 1; ALUResult_i = 32'h80; MemData_i = 32'h55; WriteReg_i = 9;
        #1;
        if (stall_o) stalls++;
        for (int w = 0; w < 3; w++) begin
            @(negedge clk_i);
            if (w == 0) begin
                MemWr_i = 0; MemRd_i = 1; ALUResult_i = 32'h44; MemData_i = 32'hFFFFFFFF;
            end
            #1;
            if (stall_o) stalls++;
            if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h80 ||
                mem_wdata_o !== 32'h55 || RegWrite_o !== 1'b0) bad++;
        end
        @(negedge clk_i);
        idle_inputs();
        ALUResult_i = 32'h44;
        mem_ack_i = 1; mem_rdata_i = 32'h12345678;
        #1;
        if (stall_o) stalls++;
        if (mem_addr_o !== 32'h80 || mem_wdata_o !== 32'h55 || RegWrite_o !== 1'b0) bad++;
        nTests++;
        if (bad != 0) begin
            nFail++; $display("FAIL store_busy_stable: %0d bad cycles want 0", bad);
        end
        @(negedge clk_i);
        mem_ack_i = 0; mem_rdata_i = 0;
        nTests++;
        if (mem_req_o !== 1'b0 || RegWrite_o !== 1'b0 || ReadData_o !== 32'd0 ||
            ALUResult_o !== 32'h80) begin
            nFail++; $display("FAIL store_done: req=%b rw=%b rd=%h alu=%h want 0 0 0 80",
                              mem_req_o, RegWrite_o, ReadData_o, ALUResult_o);
        end
        nTests++;
        if (stalls != 4) begin
            nFail++; $display("FAIL store_stall_cycles: got %0d want 4", stalls);
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk_i);
        MemRd_i = 1; RegWrite_i = 1; ALUResult_i = 32'h42; WriteReg_i = 3;
        #1;
        nTests++;
        if (stall_o !== 1'b0 || err_o !== 1'b0) begin
            nFail++; $display("FAIL misalign_pre: stall=%b err=%b want 0 0", stall_o, err_o);
        end
        @(negedge clk_i);
        MemRd_i = 0; MemWr_i = 1; ALUResult_i = 32'h81;
        nTests++;
        if (mem_req_o !== 1'b0 || err_o !== 1'b1 || err_addr_o !== 32'h42 ||
            RegWrite_o !== 1'b0) begin
            nFail++; $display("FAIL misalign_err: req=%b err=%b eaddr=%h rw=%b want 0 1 42 0",
                              mem_req_o, err_o, err_addr_o, RegWrite_o);
        end
        @(negedge clk_i);
        idle_inputs();
        nTests++;
        if (err_addr_o !== 32'h42 || mem_req_o !== 1'b0) begin
            nFail++; $display("FAIL misalign_sticky: eaddr=%h req=%b want 42 0",
                              err_addr_o, mem_req_o);
        end
    endtask

    task automatic test_timeout();
        int reqs = 0;
        int badStall = 0;
        @(negedge clk_i);
        rst_i = 0;
        @(negedge clk_i);
        rst_i = 1;
        MemRd_i = 1; RegWrite_i = 1; ALUResult_i = 32'h100; WriteReg_i = 4;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            if (i == 0) idle_inputs();
            #1;
            if (mem_req_o) reqs++;
            if (i < 3 && stall_o !== 1'b1) badStall++;
            if (i >= 3 && stall_o !== 1'b0) badStall++;
        end
        nTests++;
        if (reqs != 4 || badStall != 0) begin
            nFail++; $display("FAIL timeout_req: req cycles %0d want 4, bad stalls %0d want 0",
                              reqs, badStall);
        end
        nTests++;
        if (err_o !== 1'b1 || err_addr_o !== 32'h100 || RegWrite_o !== 1'b0) begin
            nFail++; $display("FAIL timeout_err: err=%b eaddr=%h rw=%b want 1 100 0",
                              err_o, err_addr_o, RegWrite_o);
        end
        @(negedge clk_i);
        RegWrite_i = 1; ALUResult_i = 32'h77; WriteReg_i = 3;
        @(negedge clk_i);
        idle_inputs();
        nTests++;
        if (RegWrite_o !== 1'b1 || ALUResult_o !== 32'h77 || WriteReg_o !== 5'd3) begin
            nFail++; $display("FAIL timeout_next_alu: rw=%b alu=%h wr=%0d want 1 77 3",
                              RegWrite_o, ALUResult_o, WriteReg_o);
        end
    endtask

    task automatic test_reset_busy();
        @(negedge clk_i);
        MemRd_i = 1; MemtoReg_i = 1; RegWrite_i = 1; ALUResult_i = 32'h40; WriteReg_i = 7;
        @(negedge clk_i);
        idle_inputs();
        @(negedge clk_i);
        rst_i = 0;
        #1;
        nTests++;
        if (stall_o !== 1'b0 || mem_req_o !== 1'b1) begin
            nFail++; $display("FAIL rstbusy_stall: stall=%b req=%b want 0 1", stall_o, mem_req_o);
        end
        @(negedge clk_i);
        rst_i = 1;
        nTests++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, MemtoReg_o, RegWrite_o, ReadData_o,
             ALUResult_o, WriteReg_o, err_o, err_addr_o} !== '0) begin
            nFail++; $display("FAIL rstbusy_outputs: req=%b addr=%h rw=%b alu=%h err=%b",
                              mem_req_o, mem_addr_o, RegWrite_o, ALUResult_o, err_o);
        end
        @(negedge clk_i);
        mem_ack_i = 1; mem_rdata_i = 32'hCAFEF00D;
        @(negedge clk_i);
        idle_inputs();
        nTests++;
        if (RegWrite_o !== 1'b0 || ReadData_o !== 32'd0 || mem_req_o !== 1'b0) begin
            nFail++; $display("FAIL rstbusy_late_ack: rw=%b rd=%h req=%b want 0 0 0",
                              RegWrite_o, ReadData_o, mem_req_o);
        end
    endtask

    initial begin
        idle_inputs();
        rst_i = 0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
